// File: rtl/seq_divider.sv
// Iterative signed divider: radix-2 restoring, one quotient bit per clock.
// Fixed latency regardless of operands: accept -> CALC (INP_WIDTH edges) -> FIX -> IDLE.
module seq_divider #(
    parameter int INP_WIDTH = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [INP_WIDTH-1:0] i_dividend,
    input  logic [INP_WIDTH-1:0] i_divisor,
    output logic                 o_in_ready,
    output logic                 o_out_valid,
    output logic [INP_WIDTH-1:0] o_quotient,
    output logic [INP_WIDTH-1:0] o_remainder,
    output logic                 o_div_by_zero,
    output logic                 o_overflow
);

    localparam int W = INP_WIDTH;
    localparam logic [W-1:0]         MaxPos  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         MinNeg  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t               r_state;
    logic [W-1:0]         r_quo;      // dividend magnitude, shifted out as quotient bits shift in
    logic [W-1:0]         r_dvs;      // divisor magnitude
    logic [W-1:0]         r_rem;      // partial remainder; always below 2^W
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sign_q;
    logic                 r_sign_r;
    logic                 r_dbz;
    logic                 r_ovf;
    logic                 r_out_valid;
    logic [W-1:0]         r_quotient;
    logic [W-1:0]         r_remainder;
    logic                 r_div_by_zero;
    logic                 r_overflow;

    logic [W-1:0] w_dvd_mag;
    logic [W-1:0] w_dvs_mag;
    logic [W:0]   w_shift;
    logic [W:0]   w_trial;
    logic         w_bit;
    logic [W-1:0] w_quo_signed;
    logic [W-1:0] w_rem_signed;

    // Operand magnitudes, one restoring step, and sign correction of the result
    always_comb begin
        // Most-negative maps to 2^(W-1), which still fits as an unsigned W-bit value
        w_dvd_mag    = i_dividend[W-1] ? (W'(0) - i_dividend) : i_dividend;
        w_dvs_mag    = i_divisor[W-1] ? (W'(0) - i_divisor) : i_divisor;
        // W+1 bits so the trial subtraction cannot wrap
        w_shift      = {r_rem, r_quo[W-1]};
        w_trial      = w_shift - {1'b0, r_dvs};
        w_bit        = ~w_trial[W];
        w_quo_signed = r_sign_q ? (W'(0) - r_quo) : r_quo;
        w_rem_signed = r_sign_r ? (W'(0) - r_rem) : r_rem;
    end

    // Control FSM, datapath iteration and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_dbz         <= 1'b0;
            r_ovf         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_quo    <= w_dvd_mag;
                        r_dvs    <= w_dvs_mag;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_sign_q <= i_dividend[W-1] ^ i_divisor[W-1];
                        r_sign_r <= i_dividend[W-1];
                        r_dbz    <= (i_divisor == '0);
                        r_ovf    <= (i_dividend == MinNeg) && (i_divisor == '1);
                        r_state  <= StCalc;
                    end
                end
                StCalc: begin
                    r_rem <= w_bit ? w_trial[W-1:0] : w_shift[W-1:0];
                    r_quo <= {r_quo[W-2:0], w_bit};
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                    if (r_cnt == CntLast) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    if (r_dbz) begin
                        // Divide by zero: saturate toward the dividend's sign; the
                        // iteration left |dividend| in r_rem, so remainder = dividend
                        r_quotient  <= r_sign_r ? MinNeg : MaxPos;
                        r_remainder <= w_rem_signed;
                    end else if (r_ovf) begin
                        r_quotient  <= MaxPos;
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= w_quo_signed;
                        r_remainder <= w_rem_signed;
                    end
                    r_div_by_zero <= r_dbz;
                    r_overflow    <= r_ovf && !r_dbz;
                    r_out_valid   <= 1'b1;
                    r_state       <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready    = (r_state == StIdle);
    assign o_out_valid   = r_out_valid;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (INP_WIDTH=8): stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_seq_divider;

    localparam int W   = 8;
    localparam int LAT = W + 1;   // accept edge to the edge that raises out_valid
    localparam int GAP = W + 2;   // accept-to-accept spacing with start held high

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    seq_divider #(
        .INP_WIDTH(W),
        .CNT_WIDTH(4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_dividend   (dividend),
        .i_divisor    (divisor),
        .o_in_ready   (in_ready),
        .o_out_valid  (out_valid),
        .o_quotient   (quotient),
        .o_remainder  (remainder),
        .o_div_by_zero(div_by_zero),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int ovf;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_acc = -1;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference for random vectors
    task automatic model(input int a, input int b, output int q, output int r,
                         output int dbz, output int ovf);
        dbz = 0;
        ovf = 0;
        if (b == 0) begin
            q   = (a >= 0) ? 127 : -128;
            r   = a;
            dbz = 1;
        end else if (a == -128 && b == -1) begin
            q   = 127;
            r   = 0;
            ovf = 1;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issue one request; junk operands are driven while waiting for in_ready
    task automatic send(input int a, input int b, input int q, input int r, input int dbz,
                        input int ovf, input bit push, input bit burst);
        exp_t e;
        int   budget = 40;
        @(negedge clk);
        while (!in_ready) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(negedge clk);
            budget--;
            if (budget == 0) begin
                fail("in_ready timeout");
                return;
            end
        end
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.acc = cyc;
        if (push) sb.push_back(e);
        if (burst && last_acc >= 0) chk("accept spacing", cyc - last_acc, GAP);
        last_acc = cyc;
        if (!burst) begin
            @(negedge clk);
            start    = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
        end
    endtask

    task automatic drain();
        int budget = 200;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() > 0) fail("result timeout");
    endtask

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        if (out_valid) begin
            if (prev_valid) fail("out_valid pulse width");
            chk("in_ready during out_valid", int'(in_ready), 1);
            if (sb.size() == 0) begin
                fail("unexpected out_valid");
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("quotient %0d/%0d", mon_e.a, mon_e.b),
                    int'($signed(quotient)), mon_e.q);
                chk($sformatf("remainder %0d/%0d", mon_e.a, mon_e.b),
                    int'($signed(remainder)), mon_e.r);
                chk($sformatf("div_by_zero %0d/%0d", mon_e.a, mon_e.b),
                    int'(div_by_zero), mon_e.dbz);
                chk($sformatf("overflow %0d/%0d", mon_e.a, mon_e.b),
                    int'(overflow), mon_e.ovf);
                chk($sformatf("latency %0d/%0d", mon_e.a, mon_e.b), cyc - mon_e.acc, LAT);
                if (mon_e.dbz == 0 && mon_e.ovf == 0) begin
                    chk($sformatf("invariant %0d/%0d", mon_e.a, mon_e.b),
                        int'($signed(quotient)) * mon_e.b + int'($signed(remainder)), mon_e.a);
                    chk($sformatf("rem bound %0d/%0d", mon_e.a, mon_e.b),
                        int'(iabs(int'($signed(remainder))) < iabs(mon_e.b)), 1);
                end
            end
        end
        prev_valid <= out_valid;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " quotient"}, int'(quotient), 0);
        chk({tag, " remainder"}, int'(remainder), 0);
        chk({tag, " div_by_zero"}, int'(div_by_zero), 0);
        chk({tag, " overflow"}, int'(overflow), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int q, r, dbz, ovf, a, b;

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic and sign combinations
        send(100, 7, 14, 2, 0, 0, 1, 0);
        send(-100, 7, -14, -2, 0, 0, 1, 0);
        send(100, -7, -14, 2, 0, 0, 1, 0);
        send(-100, -7, 14, -2, 0, 0, 1, 0);
        send(0, 5, 0, 0, 0, 0, 1, 0);
        send(7, 100, 0, 7, 0, 0, 1, 0);
        // Corner flags
        send(-128, -1, 127, 0, 0, 1, 1, 0);
        send(5, 0, 127, 5, 1, 0, 1, 0);
        send(-5, 0, -128, -5, 1, 0, 1, 0);
        send(-128, 1, -128, 0, 0, 0, 1, 0);

        // start held high with junk operands while busy
        drain();
        last_acc = -1;
        send(50, 7, 7, 1, 0, 0, 1, 1);
        send(-77, 3, -25, -2, 0, 0, 1, 1);
        send(127, -128, 0, 127, 0, 0, 1, 1);
        send(-128, 127, -1, -1, 0, 0, 1, 1);
        @(negedge clk);
        start = 1'b0;

        // Abort during CALC iteration 4
        drain();
        send(100, 7, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid-op reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        send(50, 3, 16, 2, 0, 0, 1, 0);

        // Random pairs against the reference model
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = (i % 20 == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            model(a, b, q, r, dbz, ovf);
            send(a, b, q, r, dbz, ovf, 1, 0);
        end

        drain();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
